// File: rtl/replace_num_packet_rx.sv
// Assembles {addr,data} replace-number write packets from a UART byte stream.
// Optional trailing XOR checksum byte enabled by defining REPLACE_NUM_CHECKSUM_EN.
module replace_num_packet_rx #(
  parameter int          ADDR_WIDTH     = 8,
  parameter int          DATA_WIDTH     = 16,
  parameter logic [7:0]  MSG_ID         = 8'h52,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_packet,
  output logic                             wr_en,
  output logic                             busy,
`ifdef REPLACE_NUM_CHECKSUM_EN
  output logic                             err_checksum,
`endif
  output logic                             err_timeout
);

  localparam int AB  = (ADDR_WIDTH + 7) / 8;
  localparam int DB  = (DATA_WIDTH + 7) / 8;
  localparam int AW8 = AB * 8;
  localparam int DW8 = DB * 8;
  localparam int PW  = ADDR_WIDTH + DATA_WIDTH;
  localparam int TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW  = $clog2(AB + DB + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
`ifdef REPLACE_NUM_CHECKSUM_EN
    S_CHK,
`endif
    S_COMMIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [AW8-1:0]  addr_q, addr_d;
  logic [DW8-1:0]  data_q, data_d;
  logic [PW-1:0]   pkt_q, pkt_d;
  logic            tmo_err_q, tmo_err_d;
  logic            tmo_exp;
`ifdef REPLACE_NUM_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
  logic            ck_err_q, ck_err_d;
`endif

  assign tmo_exp = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    data_d    = data_q;
    pkt_d     = pkt_q;
    tmo_err_d = 1'b0;
`ifdef REPLACE_NUM_CHECKSUM_EN
    chk_d     = chk_q;
    ck_err_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_COMMIT: begin
        state_d = S_IDLE;
        if (rx_valid && rx_data == MSG_ID) begin
          state_d = S_ADDR;
          cnt_d   = '0;
          tmo_d   = '0;
`ifdef REPLACE_NUM_CHECKSUM_EN
          chk_d   = MSG_ID;
`endif
        end
      end
      default: begin
        // Mid-packet: a byte always beats an expiring timeout.
        if (rx_valid) begin
          tmo_d = '0;
`ifdef REPLACE_NUM_CHECKSUM_EN
          chk_d = chk_q ^ rx_data;
`endif
          if (state_q == S_ADDR) begin
            addr_d = (addr_q << 8) | AW8'(rx_data);
            if (cnt_q == CW'(AB - 1)) begin
              state_d = S_DATA;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (state_q == S_DATA) begin
            data_d = (data_q << 8) | DW8'(rx_data);
            if (cnt_q == CW'(DB - 1)) begin
              cnt_d = '0;
`ifdef REPLACE_NUM_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_COMMIT;
              pkt_d   = {addr_q[ADDR_WIDTH-1:0], data_d[DATA_WIDTH-1:0]};
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
`ifdef REPLACE_NUM_CHECKSUM_EN
          else begin
            if (rx_data == chk_q) begin
              state_d = S_COMMIT;
              pkt_d   = {addr_q[ADDR_WIDTH-1:0], data_q[DATA_WIDTH-1:0]};
            end else begin
              state_d  = S_IDLE;
              ck_err_d = 1'b1;
            end
          end
`endif
        end else if (tmo_exp) begin
          state_d   = S_IDLE;
          tmo_d     = '0;
          tmo_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      pkt_q     <= '0;
      tmo_err_q <= 1'b0;
`ifdef REPLACE_NUM_CHECKSUM_EN
      chk_q     <= '0;
      ck_err_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      pkt_q     <= pkt_d;
      tmo_err_q <= tmo_err_d;
`ifdef REPLACE_NUM_CHECKSUM_EN
      chk_q     <= chk_d;
      ck_err_q  <= ck_err_d;
`endif
    end
  end

  // Packet is loaded on the edge into COMMIT so it is already stable while wr_en is high.
  assign wr_packet   = pkt_q;
  assign wr_en       = (state_q == S_COMMIT);
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = tmo_err_q;
`ifdef REPLACE_NUM_CHECKSUM_EN
  assign err_checksum = ck_err_q;
`endif

endmodule
